// File: rtl/eject_pkg.sv
// Shared types and constants for the MinBD ejector: flit layout, widths and default FIFO depth.
package eject_pkg;

  localparam int COORD_W      = 4;
  localparam int AGE_W        = 4;
  localparam int NUM_CH       = 4;
  localparam int EJ_DEPTH_DEF = 4;

  typedef struct packed {
    logic               vld;
    logic [COORD_W-1:0] dst_x;
    logic [COORD_W-1:0] dst_y;
    logic [AGE_W-1:0]   age;
  } flit_int_t;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/eject_fifo.sv
// Ejection FIFO: registered head, no fall-through, explicit pointer wrap so any depth >= 2 works.
module eject_fifo
  import eject_pkg::*;
#(
  parameter int EJ_DEPTH = EJ_DEPTH_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           push,
  input  logic                           pop,
  input  flit_int_t                      din,
  output flit_int_t                      dout,
  output logic                           vld,
  output logic [$clog2(EJ_DEPTH+1)-1:0]  count
);

  localparam int PTR_W = $clog2(EJ_DEPTH);
  localparam int CNT_W = $clog2(EJ_DEPTH+1);

  flit_int_t        mem_r [EJ_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;

  // Storage array; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push) begin
        wr_ptr_r <= (wr_ptr_r == PTR_W'(EJ_DEPTH-1)) ? {PTR_W{1'b0}} : wr_ptr_r + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_r <= (rd_ptr_r == PTR_W'(EJ_DEPTH-1)) ? {PTR_W{1'b0}} : rd_ptr_r + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign vld   = (count_r != {CNT_W{1'b0}});
  assign count = count_r;

endmodule

// File: rtl/eject.sv
// MinBD ejector: removes the oldest local flit from the four channels into an ejection FIFO.
// Optional EJECT_STATS_EN adds ej_cnt / ej_defl_cnt statistics counters.
module eject
  import eject_pkg::*;
#(
  parameter int CUR_X    = 0,
  parameter int CUR_Y    = 0,
  parameter int EJ_DEPTH = EJ_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  flit_int_t   din_0,
  input  flit_int_t   din_1,
  input  flit_int_t   din_2,
  input  flit_int_t   din_3,
  output flit_int_t   dout_0,
  output flit_int_t   dout_1,
  output flit_int_t   dout_2,
  output flit_int_t   dout_3,
  output logic        eject_vld,
  output flit_int_t   eject_flit,
  input  logic        eject_rdy
`ifdef EJECT_STATS_EN
  ,output logic [31:0] ej_cnt
  ,output logic [31:0] ej_defl_cnt
`endif
);

  localparam int CNT_W = $clog2(EJ_DEPTH+1);

  flit_int_t        din_s  [NUM_CH];
  flit_int_t        dout_s [NUM_CH];
  logic [NUM_CH-1:0] cand_s;
  logic [NUM_CH-1:0] sel_oh_s;
  logic             b01_s, b23_s, v01_s, v23_s, hi_s, any_s;
  logic [AGE_W-1:0] a01_s, a23_s;
  logic [1:0]       sel_idx_s;
  logic             push_s, pop_s;
  logic [CNT_W-1:0] count_s;
  flit_int_t        sel_flit_s;

  assign din_s[0] = din_0;
  assign din_s[1] = din_1;
  assign din_s[2] = din_2;
  assign din_s[3] = din_3;

  // Candidate detection: valid flits addressed to this router.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      cand_s[i] = din_s[i].vld &&
                  (din_s[i].dst_x == COORD_W'(CUR_X)) &&
                  (din_s[i].dst_y == COORD_W'(CUR_Y));
    end
  end

  // Two-level age tree; strict '>' keeps the lower channel on equal ages.
  always_comb begin
    b01_s     = cand_s[1] && (!cand_s[0] || (din_s[1].age > din_s[0].age));
    b23_s     = cand_s[3] && (!cand_s[2] || (din_s[3].age > din_s[2].age));
    v01_s     = cand_s[0] || cand_s[1];
    v23_s     = cand_s[2] || cand_s[3];
    a01_s     = b01_s ? din_s[1].age : din_s[0].age;
    a23_s     = b23_s ? din_s[3].age : din_s[2].age;
    hi_s      = v23_s && (!v01_s || (a23_s > a01_s));
    sel_idx_s = hi_s ? {1'b1, b23_s} : {1'b0, b01_s};
    any_s     = v01_s || v23_s;
  end

  assign pop_s      = eject_vld && eject_rdy;
  assign push_s     = any_s && ((count_s < CNT_W'(EJ_DEPTH)) || pop_s) && !reset;
  assign sel_flit_s = din_s[sel_idx_s];

  // Clear vld only on the channel actually written into the FIFO.
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      sel_oh_s[i]   = push_s && (sel_idx_s == 2'(i));
      dout_s[i]     = din_s[i];
      dout_s[i].vld = din_s[i].vld && !sel_oh_s[i];
    end
  end

  assign dout_0 = dout_s[0];
  assign dout_1 = dout_s[1];
  assign dout_2 = dout_s[2];
  assign dout_3 = dout_s[3];

  eject_fifo #(.EJ_DEPTH(EJ_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (sel_flit_s),
    .dout  (eject_flit),
    .vld   (eject_vld),
    .count (count_s)
  );

`ifdef EJECT_STATS_EN
  logic [31:0] ej_cnt_r;
  logic [31:0] ej_defl_cnt_r;

  // Ejection and deflection statistics; every candidate not pushed is a deflection.
  always_ff @(posedge clk) begin
    if (reset) begin
      ej_cnt_r      <= 32'd0;
      ej_defl_cnt_r <= 32'd0;
    end else begin
      ej_cnt_r      <= ej_cnt_r + 32'(push_s);
      ej_defl_cnt_r <= ej_defl_cnt_r + 32'(popcount4(cand_s)) - 32'(push_s);
    end
  end

  assign ej_cnt      = ej_cnt_r;
  assign ej_defl_cnt = ej_defl_cnt_r;
`endif

endmodule

// File: tb/tb_eject.sv
// Self-checking bench for eject: directed scenarios plus randomized traffic against a queue model.
module tb_eject;
  import eject_pkg::*;

  localparam int CX    = 3;
  localparam int CY    = 5;
  localparam int DEPTH = 4;

  logic      clk = 1'b0;
  logic      reset = 1'b1;
  flit_int_t din_0, din_1, din_2, din_3;
  flit_int_t dout_0, dout_1, dout_2, dout_3;
  logic      eject_vld;
  flit_int_t eject_flit;
  logic      eject_rdy = 1'b0;
`ifdef EJECT_STATS_EN
  logic [31:0] ej_cnt, ej_defl_cnt;
  int          m_ej = 0, m_defl = 0;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  flit_int_t q[$];

  eject #(.CUR_X(CX), .CUR_Y(CY), .EJ_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .din_0(din_0), .din_1(din_1), .din_2(din_2), .din_3(din_3),
    .dout_0(dout_0), .dout_1(dout_1), .dout_2(dout_2), .dout_3(dout_3),
    .eject_vld(eject_vld), .eject_flit(eject_flit), .eject_rdy(eject_rdy)
`ifdef EJECT_STATS_EN
    , .ej_cnt(ej_cnt), .ej_defl_cnt(ej_defl_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic flit_int_t mk(input logic v, input bit local_dst, input int age);
    flit_int_t f;
    f.vld   = v;
    f.dst_x = local_dst ? COORD_W'(CX) : COORD_W'(CX + 1 + int'($urandom_range(0, 10)));
    f.dst_y = local_dst ? COORD_W'(CY) : COORD_W'($urandom_range(0, 15));
    f.age   = AGE_W'(age);
    return f;
  endfunction

  function automatic flit_int_t rnd(input int p_local, input int max_age);
    flit_int_t f;
    f.vld   = ($urandom_range(0, 3) != 0);
    f.dst_x = COORD_W'($urandom_range(0, 15));
    f.dst_y = COORD_W'($urandom_range(0, 15));
    if (int'($urandom_range(0, 99)) < p_local) begin
      f.dst_x = COORD_W'(CX);
      f.dst_y = COORD_W'(CY);
    end
    f.age = AGE_W'($urandom_range(0, max_age));
    return f;
  endfunction

  // Apply one cycle of inputs, check against the model, then advance the model over the edge.
  task automatic step(input flit_int_t f0, f1, f2, f3, input logic rdy, input logic rst);
    flit_int_t f[4];
    flit_int_t e;
    int  best, ncand;
    bit  pop, push;
    @(negedge clk);
    f[0] = f0; f[1] = f1; f[2] = f2; f[3] = f3;
    din_0 = f0; din_1 = f1; din_2 = f2; din_3 = f3;
    eject_rdy = rdy;
    reset = rst;
    #1;
    best  = -1;
    ncand = 0;
    for (int i = 0; i < 4; i++) begin
      if (f[i].vld && f[i].dst_x == COORD_W'(CX) && f[i].dst_y == COORD_W'(CY)) begin
        ncand++;
        if (best < 0 || f[i].age > f[best].age) best = i;
      end
    end
    pop  = (q.size() != 0) && rdy;
    push = (best >= 0) && ((q.size() < DEPTH) || pop) && !rst;
    check_val("eject_vld", 32'(eject_vld), 32'(q.size() != 0));
    if (q.size() != 0) check_val("eject_flit", 32'(eject_flit), 32'(q[0]));
    for (int i = 0; i < 4; i++) begin
      e = f[i];
      if (push && i == best) e.vld = 1'b0;
      case (i)
        0: check_val("dout_0", 32'(dout_0), 32'(e));
        1: check_val("dout_1", 32'(dout_1), 32'(e));
        2: check_val("dout_2", 32'(dout_2), 32'(e));
        default: check_val("dout_3", 32'(dout_3), 32'(e));
      endcase
    end
`ifdef EJECT_STATS_EN
    check_val("ej_cnt", ej_cnt, 32'(m_ej));
    check_val("ej_defl_cnt", ej_defl_cnt, 32'(m_defl));
    if (rst) begin
      m_ej = 0; m_defl = 0;
    end else begin
      m_ej   = m_ej + int'(push);
      m_defl = m_defl + ncand - int'(push);
    end
`endif
    if (rst) begin
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) q.push_back(f[best]);
    end
  endtask

  initial begin
    flit_int_t z, a, b;
    z = '0;
    din_0 = z; din_1 = z; din_2 = z; din_3 = z;
    step(z, z, z, z, 1'b0, 1'b1);
    step(z, z, z, z, 1'b0, 1'b1);
    step(z, z, z, z, 1'b0, 1'b0);

    // Single local flit on channel 2, then see it at the head.
    step(z, z, mk(1'b1, 1'b1, 6), z, 1'b0, 1'b0);
    step(z, z, z, z, 1'b1, 1'b0);

    // Older flit wins; equal ages go to channel 0.
    a = mk(1'b1, 1'b1, 3); b = mk(1'b1, 1'b1, 7);
    step(a, z, z, b, 1'b1, 1'b0);
    a = mk(1'b1, 1'b1, 5); b = mk(1'b1, 1'b1, 5);
    step(a, z, z, b, 1'b1, 1'b0);
    step(z, z, z, z, 1'b1, 1'b0);
    step(z, z, z, z, 1'b1, 1'b0);

    // Fill with NI stalled; the fifth local flit deflects.
    for (int i = 0; i < DEPTH + 1; i++) step(mk(1'b1, 1'b1, i), z, z, z, 1'b0, 1'b0);
    // Full with a pop: simultaneous push and pop, then drain in order.
    step(z, mk(1'b1, 1'b1, 9), z, z, 1'b1, 1'b0);
    for (int i = 0; i < DEPTH + 1; i++) step(z, z, z, z, 1'b1, 1'b0);

    // Non-local traffic only.
    step(mk(1'b1, 1'b0, 1), mk(1'b1, 1'b0, 2), mk(1'b1, 1'b0, 3), mk(1'b1, 1'b0, 4), 1'b0, 1'b0);

    // Reset with three queued flits and a local flit on channel 1.
    for (int i = 0; i < 3; i++) step(z, z, mk(1'b1, 1'b1, i), z, 1'b0, 1'b0);
    step(z, mk(1'b1, 1'b1, 8), z, z, 1'b0, 1'b1);
    step(z, z, z, z, 1'b1, 1'b0);

    // Randomized phases with varying NI readiness and locality.
    for (int ph = 0; ph < 4; ph++) begin
      for (int c = 0; c < 400; c++) begin
        step(rnd(20 + ph * 20, (ph % 2 == 0) ? 3 : 15), rnd(20 + ph * 20, 3),
             rnd(40, 15), rnd(30 + ph * 10, 7),
             (int'($urandom_range(0, 99)) < ph * 30), ($urandom_range(0, 99) == 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
